// File: rtl/raybox_pkg.sv
// Shared constants for the raybox input path: button bit positions and
// the debounce counter width helper.
package raybox_pkg;

  localparam int BTN_F   = 3;
  localparam int BTN_L   = 2;
  localparam int BTN_R   = 1;
  localparam int BTN_B   = 0;
  localparam int NUM_BTN = 4;

  function automatic int debounce_cnt_w(input int cycles);
    return (cycles < 2) ? 1 : $clog2(cycles);
  endfunction

endpackage

// File: rtl/input_debounce.sv
// One raw active-low input: 2-flop synchronizer followed by a stable-state
// debouncer that flips after DEBOUNCE_CYCLES consecutive differing clocks.
module input_debounce
  import raybox_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_raw_n,
  output logic o_stable_n
);

  localparam int CW = debounce_cnt_w(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic          r_sync1;
  logic          r_sync2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_differ;
  logic          w_flip;

  assign w_differ = (r_sync2 != r_stable);
  // Counter value CNT_LAST plus the current differing clock makes DEBOUNCE_CYCLES.
  assign w_flip   = w_differ && (r_cnt == CNT_LAST);

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_stable <= 1'b1;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_raw_n;
      r_sync2 <= r_sync1;
      if (!w_differ) begin
        r_cnt <= '0;
      end else if (w_flip) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CW'(1);
      end
    end
  end

  assign o_stable_n = r_stable;

endmodule

// File: rtl/raybox_input_ctrl.sv
// Raybox player input: debounced buttons latched into per-frame move
// commands at each vsync start, plus a map-view request.
module raybox_input_ctrl
  import raybox_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 250000,
  parameter bit VSYNC_ACTIVE    = 1'b0,
  parameter int MAP_TOGGLE      = 1
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [3:0]   btn_n,
  input  logic         map_n,
  input  logic         vsync,
  output logic         moveF,
  output logic         moveL,
  output logic         moveR,
  output logic         moveB,
  output logic         show_map,
  output logic         frame_tick
);

  logic [NUM_BTN-1:0] w_btn_stable_n;
  logic [NUM_BTN-1:0] w_pressed;
  logic               w_map_stable_n;
  logic               w_map_press;
  logic               w_tick;

  logic r_vs1;
  logic r_vs2;
  logic r_map_d;
  logic r_pending;
  logic r_tick;
  logic r_moveF;
  logic r_moveL;
  logic r_moveR;
  logic r_moveB;
  logic r_show_map;

  for (genvar g = 0; g < NUM_BTN; g++) begin : g_btn
    input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_btn_db (
      .i_clk      (clk),
      .i_reset    (reset),
      .i_raw_n    (btn_n[g]),
      .o_stable_n (w_btn_stable_n[g])
    );
  end

  input_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_map_db (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_raw_n    (map_n),
    .o_stable_n (w_map_stable_n)
  );

  assign w_pressed   = ~w_btn_stable_n;
  assign w_map_press = r_map_d & ~w_map_stable_n;
  // r_vs2 doubles as the vsync history bit.
  assign w_tick      = (r_vs1 == VSYNC_ACTIVE) && (r_vs2 != VSYNC_ACTIVE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_vs1      <= ~VSYNC_ACTIVE;
      r_vs2      <= ~VSYNC_ACTIVE;
      r_map_d    <= 1'b1;
      r_pending  <= 1'b0;
      r_tick     <= 1'b0;
      r_moveF    <= 1'b0;
      r_moveL    <= 1'b0;
      r_moveR    <= 1'b0;
      r_moveB    <= 1'b0;
      r_show_map <= 1'b0;
    end else begin
      r_vs1   <= vsync;
      r_vs2   <= r_vs1;
      r_map_d <= w_map_stable_n;
      r_tick  <= w_tick;
      if (w_tick) begin
        r_moveF <= w_pressed[BTN_F] & ~w_pressed[BTN_B];
        r_moveB <= w_pressed[BTN_B] & ~w_pressed[BTN_F];
        r_moveL <= w_pressed[BTN_L] & ~w_pressed[BTN_R];
        r_moveR <= w_pressed[BTN_R] & ~w_pressed[BTN_L];
        if (MAP_TOGGLE != 0) begin
          // A press landing on the tick clock is consumed here, not left pending.
          if (r_pending || w_map_press) r_show_map <= ~r_show_map;
        end else begin
          r_show_map <= ~w_map_stable_n;
        end
        r_pending <= 1'b0;
      end else if (w_map_press) begin
        r_pending <= 1'b1;
      end
    end
  end

  assign moveF      = r_moveF;
  assign moveL      = r_moveL;
  assign moveR      = r_moveR;
  assign moveB      = r_moveB;
  assign show_map   = r_show_map;
  assign frame_tick = r_tick;

endmodule
